// File: rtl/aer_out_sink.sv
// Output-AER receiver: 4-phase REQ/ACK handshake with programmable acknowledge delay,
// first-word-fall-through capture FIFO, saturating event counter and stall/drop/protocol flags.
module aer_out_sink #(
  parameter int AER_WIDTH    = 12,
  parameter int ACK_DELAY    = 6,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_WIDTH    = 16,
  parameter int DROP_ON_FULL = 0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [AER_WIDTH-1:0] AEROUT_ADDR,
  input  logic                 AEROUT_REQ,
  output logic                 AEROUT_ACK,
  input  logic                 RD_EN,
  output logic [AER_WIDTH-1:0] RD_DATA,
  output logic                 RD_VALID,
  output logic                 FIFO_FULL,
  output logic [CNT_WIDTH-1:0] EVENT_CNT,
  input  logic                 CLR,
  output logic                 STALL,
  output logic                 OVERFLOW,
  output logic                 PROTO_ERR
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] DLY_LOAD = 8'(ACK_DELAY - 1);

  typedef enum logic [1:0] {IDLE, DELAY, ACK_HI} state_t;

  state_t               r_state, w_state_nxt;
  logic [7:0]           r_dcnt, w_dcnt_nxt;
  logic                 r_ack, w_ack_nxt;
  logic                 w_push, w_drop, w_perr, w_stall;
  logic                 r_stall, r_ovf, r_perr;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [AW:0]          r_wptr, r_rptr;
  logic [AER_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic                 w_full, w_empty, w_pop;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Occupancy comes from registered pointers, so a same-cycle pop never unblocks a push
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_pop   = RD_EN && !w_empty;

  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_ack_nxt   = r_ack;
    w_push      = 1'b0;
    w_drop      = 1'b0;
    w_perr      = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        w_ack_nxt = 1'b0;
        if (AEROUT_REQ) begin
          w_state_nxt = DELAY;
          w_dcnt_nxt  = DLY_LOAD;
        end
      end
      DELAY: begin
        if (!AEROUT_REQ) begin
          w_perr      = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_dcnt != 8'd0) begin
          w_dcnt_nxt = r_dcnt - 8'd1;
        end else if (!w_full) begin
          w_push      = 1'b1;
          w_ack_nxt   = 1'b1;
          w_state_nxt = ACK_HI;
        end else if (DROP_ON_FULL != 0) begin
          w_drop      = 1'b1;
          w_ack_nxt   = 1'b1;
          w_state_nxt = ACK_HI;
        end else begin
          w_stall = 1'b1;
        end
      end
      ACK_HI: begin
        if (!AEROUT_REQ) begin
          w_ack_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_ack_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_dcnt  <= 8'd0;
      r_ack   <= 1'b0;
      r_stall <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_ack   <= w_ack_nxt;
      r_stall <= w_stall;
    end
  end

  // CLR and a push in the same cycle leave the counter at one, not zero
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      if (w_push)   r_cnt <= CLR ? CNT_WIDTH'(1) : sat_inc(r_cnt);
      else if (CLR) r_cnt <= '0;
      if (w_drop)   r_ovf <= 1'b1;
      else if (CLR) r_ovf <= 1'b0;
      if (w_perr)   r_perr <= 1'b1;
      else if (CLR) r_perr <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= AEROUT_ADDR;
  end

  assign AEROUT_ACK = r_ack;
  assign RD_DATA    = r_mem[r_rptr[AW-1:0]];
  assign RD_VALID   = !w_empty;
  assign FIFO_FULL  = w_full;
  assign EVENT_CNT  = r_cnt;
  assign STALL      = r_stall;
  assign OVERFLOW   = r_ovf;
  assign PROTO_ERR  = r_perr;

endmodule

// File: tb/tb_aer_out_sink.sv
// Directed bench for aer_out_sink: a stall-mode and a drop-mode instance, both with
// a 4-entry FIFO and 4-bit counter, exercised through hand-computed handshake sequences.
module tb_aer_out_sink;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        req [2];
  logic        rd [2];
  logic        clr [2];
  logic [11:0] addr [2];
  logic        ack [2];
  logic [11:0] rd_data [2];
  logic        rd_valid [2];
  logic        full [2];
  logic [3:0]  cnt [2];
  logic        stall [2];
  logic        ovf [2];
  logic        perr [2];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  aer_out_sink #(.AER_WIDTH(12), .ACK_DELAY(6), .FIFO_DEPTH(4), .CNT_WIDTH(4), .DROP_ON_FULL(0)) u0 (
    .CLK(CLK), .RST_N(rst_n), .AEROUT_ADDR(addr[0]), .AEROUT_REQ(req[0]), .AEROUT_ACK(ack[0]),
    .RD_EN(rd[0]), .RD_DATA(rd_data[0]), .RD_VALID(rd_valid[0]), .FIFO_FULL(full[0]),
    .EVENT_CNT(cnt[0]), .CLR(clr[0]), .STALL(stall[0]), .OVERFLOW(ovf[0]), .PROTO_ERR(perr[0]));

  aer_out_sink #(.AER_WIDTH(12), .ACK_DELAY(6), .FIFO_DEPTH(4), .CNT_WIDTH(4), .DROP_ON_FULL(1)) u1 (
    .CLK(CLK), .RST_N(rst_n), .AEROUT_ADDR(addr[1]), .AEROUT_REQ(req[1]), .AEROUT_ACK(ack[1]),
    .RD_EN(rd[1]), .RD_DATA(rd_data[1]), .RD_VALID(rd_valid[1]), .FIFO_FULL(full[1]),
    .EVENT_CNT(cnt[1]), .CLR(clr[1]), .STALL(stall[1]), .OVERFLOW(ovf[1]), .PROTO_ERR(perr[1]));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full handshake; n is the number of edges from raising REQ until ACK is seen high
  task automatic run_event(input int sel, input logic [11:0] a, output int n);
    addr[sel] = a;
    req[sel]  = 1'b1;
    n = 0;
    while (ack[sel] !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("ack_wait", 32'(n < 100), 1);
    req[sel] = 1'b0;
    tick();
    chk("ack_fall", ack[sel], 0);
  endtask

  task automatic pop_chk(input int sel, input logic [11:0] exp, input string tag);
    chk({tag, "_valid"}, rd_valid[sel], 1);
    chk({tag, "_data"}, rd_data[sel], exp);
    rd[sel] = 1'b1;
    tick();
    rd[sel] = 1'b0;
  endtask

  initial begin
    int n;
    logic seen;
    logic [11:0] q[$];
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req[s] = 1'b0; rd[s] = 1'b0; clr[s] = 1'b0; addr[s] = 12'h000;
    end
    repeat (3) tick();
    for (int s = 0; s < 2; s++) begin
      chk("rst_ack", ack[s], 0);
      chk("rst_valid", rd_valid[s], 0);
      chk("rst_full", full[s], 0);
      chk("rst_cnt", cnt[s], 0);
      chk("rst_flags", {stall[s], ovf[s], perr[s]}, 0);
    end
    rst_n = 1'b1;
    tick();

    // single event
    run_event(0, 12'h1A5, n);
    chk("single_latency", n, 7);
    chk("single_data", rd_data[0], 12'h1A5);
    chk("single_valid", rd_valid[0], 1);
    chk("single_cnt", cnt[0], 1);
    rd[0] = 1'b1; tick(); rd[0] = 1'b0;
    chk("single_drained", rd_valid[0], 0);

    // fill to full, stall mode
    clr[0] = 1'b1; tick(); clr[0] = 1'b0;
    for (int i = 1; i <= 4; i++) run_event(0, 12'(i), n);
    chk("stall_full", full[0], 1);
    addr[0] = 12'h005;
    req[0] = 1'b1;
    repeat (12) tick();
    chk("stall_stall", stall[0], 1);
    chk("stall_ack_low", ack[0], 0);
    rd[0] = 1'b1; tick(); rd[0] = 1'b0;
    chk("stall_pop_blocks", ack[0], 0);
    chk("stall_head2", rd_data[0], 12'h002);
    tick();
    chk("stall_release_ack", ack[0], 1);
    chk("stall_release_stall", stall[0], 0);
    chk("stall_refull", full[0], 1);
    req[0] = 1'b0; tick();
    chk("stall_ack_fall", ack[0], 0);
    for (int i = 2; i <= 5; i++) pop_chk(0, 12'(i), "stall_drain");
    chk("stall_empty", rd_valid[0], 0);
    chk("stall_cnt", cnt[0], 5);

    // drop mode
    for (int i = 1; i <= 4; i++) run_event(1, 12'(i), n);
    run_event(1, 12'h005, n);
    chk("drop_latency", n, 7);
    chk("drop_ovf", ovf[1], 1);
    chk("drop_cnt", cnt[1], 4);
    chk("drop_full", full[1], 1);
    for (int i = 1; i <= 4; i++) pop_chk(1, 12'(i), "drop_drain");
    chk("drop_empty", rd_valid[1], 0);
    chk("stall_no_ovf", ovf[0], 0);

    // protocol error
    seen = 1'b0;
    addr[0] = 12'h077;
    req[0] = 1'b1;
    tick(); seen |= ack[0];
    tick(); seen |= ack[0];
    req[0] = 1'b0;
    repeat (8) begin tick(); seen |= ack[0]; end
    chk("perr_set", perr[0], 1);
    chk("perr_no_ack", seen, 0);
    chk("perr_no_push", rd_valid[0], 0);
    chk("perr_cnt", cnt[0], 5);
    clr[0] = 1'b1; tick(); clr[0] = 1'b0;
    chk("perr_clr", perr[0], 0);
    chk("perr_clr_cnt", cnt[0], 0);

    // saturation with continuous reads
    rd[0] = 1'b1;
    for (int i = 0; i < 20; i++) run_event(0, 12'(i), n);
    rd[0] = 1'b0;
    tick();
    chk("sat_cnt", cnt[0], 15);
    chk("sat_empty", rd_valid[0], 0);

    // CLR coincident with push
    addr[0] = 12'h0C1;
    req[0] = 1'b1;
    repeat (6) tick();
    clr[0] = 1'b1; tick(); clr[0] = 1'b0;
    chk("clrpush_ack", ack[0], 1);
    chk("clrpush_cnt", cnt[0], 1);
    req[0] = 1'b0; tick();
    pop_chk(0, 12'h0C1, "clrpush_pop");

    // pointer wrap: 11 events, pairs popped after each odd event
    for (int i = 0; i < 11; i++) begin
      run_event(0, 12'(12'h100 + i), n);
      q.push_back(12'(12'h100 + i));
      if (i % 2 == 1) begin
        pop_chk(0, q.pop_front(), "wrap");
        pop_chk(0, q.pop_front(), "wrap");
      end
    end
    while (q.size() > 0) pop_chk(0, q.pop_front(), "wrap_tail");
    chk("wrap_empty", rd_valid[0], 0);
    chk("wrap_cnt", cnt[0], 12);

    // reset mid-handshake
    run_event(0, 12'h00A, n);
    run_event(0, 12'h00B, n);
    run_event(0, 12'h00C, n);
    addr[0] = 12'h00D;
    req[0] = 1'b1;
    n = 0;
    while (ack[0] !== 1'b1 && n < 100) begin tick(); n++; end
    chk("rstmid_ack_up", ack[0], 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_ack", ack[0], 0);
    chk("rstmid_valid", rd_valid[0], 0);
    chk("rstmid_cnt", cnt[0], 0);
    tick(); tick();
    rst_n = 1'b1;
    n = 0;
    while (ack[0] !== 1'b1 && n < 100) begin tick(); n++; end
    chk("rstmid_latency", n, 7);
    chk("rstmid_data", rd_data[0], 12'h00D);
    chk("rstmid_cnt1", cnt[0], 1);
    req[0] = 1'b0; tick();
    chk("rstmid_ack_fall", ack[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aer_out_sink.md
# aer_out_sink

Parametrised receiver for the core's output AER bus. It performs the 4-phase REQ/ACK handshake with a programmable acknowledge delay and captures each output spike address into a first-word-fall-through FIFO. It keeps a saturating event counter and flags stall, drop and protocol-error conditions. It sits between the core's AEROUT port and the host/readout logic, and replaces the fixed-delay acknowledge generator.

## Interface
- AER_WIDTH, 12: address bit width.
- ACK_DELAY, 6: cycles from REQ sampled high to ACK high; legal range 1..255.
- FIFO_DEPTH, 16: FIFO entries; power of two, ≥2.
- CNT_WIDTH, 16: event counter width.
- DROP_ON_FULL, 0: 0 = stall the handshake while the FIFO is full; 1 = acknowledge and discard the event.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- AEROUT_ADDR  in  AER_WIDTH  spike address; stable while AEROUT_REQ is high.
- AEROUT_REQ  in  1  request; synchronous to CLK.
- AEROUT_ACK  out  1  acknowledge; registered.
- RD_EN  in  1  pop the FIFO head; ignored when empty.
- RD_DATA  out  AER_WIDTH  FIFO head; valid when RD_VALID is high.
- RD_VALID  out  1  FIFO not empty.
- FIFO_FULL  out  1  FIFO holds FIFO_DEPTH entries.
- EVENT_CNT  out  CNT_WIDTH  accepted (pushed) events; saturates at all-ones.
- CLR  in  1  synchronous clear of EVENT_CNT, OVERFLOW and PROTO_ERR.
- STALL  out  1  high while the FSM is held by a full FIFO (DROP_ON_FULL=0).
- OVERFLOW  out  1  sticky; set when an event is dropped (DROP_ON_FULL=1).
- PROTO_ERR  out  1  sticky; set when REQ falls before ACK rises.

## Operation
- **Reset values:** every output resets to 0, except RD_DATA, which is don't-care. The FSM goes to IDLE, the FIFO is empty, the counters are 0.
- **FSM states:** IDLE, DELAY, ACK_HI.
- **IDLE:** when REQ is sampled at 1, load `dcnt = ACK_DELAY-1` and go to DELAY.
- **DELAY, REQ=0:** set PROTO_ERR and go to IDLE. Nothing is pushed and ACK is never raised.
- **DELAY, dcnt≠0:** decrement dcnt.
- **DELAY, dcnt=0, FIFO not full:**
  - push AEROUT_ADDR;
  - increment EVENT_CNT, saturating;
  - set ACK=1 and go to ACK_HI.
- **DELAY, dcnt=0, FIFO full, DROP_ON_FULL=0:** hold in DELAY with STALL=1. Re-evaluate each cycle; the push happens on the first cycle the FIFO is not full.
- **DELAY, dcnt=0, FIFO full, DROP_ON_FULL=1:** no push, no count. Set OVERFLOW, set ACK=1 and go to ACK_HI.
- **ACK_HI:** when REQ is sampled at 0, set ACK=0 and go to IDLE. ACK stays high for as long as REQ is high.
- **Full evaluation:** "full" uses the registered occupancy before this cycle's pop. A simultaneous pop and push on a full FIFO is therefore still blocked, and the push lands one cycle later.
- **FIFO behaviour:**
  - First-word-fall-through: RD_DATA shows the head as soon as RD_VALID is high.
  - A pop on RD_EN·RD_VALID advances the head.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves occupancy unchanged.
  - Pointers are log2(FIFO_DEPTH) bits plus a wrap bit. Full when the indices are equal and the wrap bits differ; empty when both are equal.
- **CLR with a push in the same cycle:** EVENT_CNT becomes 1. OVERFLOW and PROTO_ERR clear. CLR does not affect the FIFO or the FSM.
- **EVENT_CNT at all-ones:** stays at all-ones.
- **RST_N low mid-handshake:** ACK drops asynchronously, FIFO contents are discarded, and the FSM returns to IDLE. A REQ still high after reset is treated as a new event.

## Timing
- **REQ rise to ACK:** REQ sampled 1 at edge t. ACK is high after edge t+ACK_DELAY, provided the FIFO is not full.
- **Push to read:** the pushed entry has RD_VALID=1 after the same edge that raises ACK.
- **ACK release:** REQ sampled 0 at edge u → ACK is 0 after edge u.
- **Back-to-back events:** IDLE can accept a new REQ on the edge after ACK falls. Minimum handshake period is ACK_DELAY+2 cycles.
- **Read latency:** RD_EN at edge r → next head (or RD_VALID=0) visible after r.
- **Output registers:** STALL, OVERFLOW, PROTO_ERR, EVENT_CNT, FIFO_FULL and RD_VALID are all registered. They update on the same edge as the state change that causes them.

## Test plan
- **Single event:** ACK_DELAY=6. Drive REQ=1 with ADDR=0x1A5, release REQ after ACK.
  - Required: ACK rises exactly 6 cycles after REQ is sampled.
  - Required: RD_DATA=0x1A5 with RD_VALID=1 and EVENT_CNT=1.
  - Required: ACK falls the cycle after REQ drops.
- **Fill to full, stall mode:** DROP_ON_FULL=0, FIFO_DEPTH=4, no reads, 5 events (addresses 1..5).
  - Required: FIFO_FULL after event 4; the 5th holds with STALL=1 and ACK=0.
  - One RD_EN pops 1; then ACK rises and 5 is pushed.
  - Reading out drains in order 2,3,4,5.
- **Drop mode:** DROP_ON_FULL=1, same 5 events.
  - Required: the 5th is acknowledged on schedule and OVERFLOW=1.
  - Required: EVENT_CNT=4; FIFO drains 1..4.
- **Protocol error:** raise REQ, drop it 2 cycles later with ACK_DELAY=6.
  - Required: PROTO_ERR=1, no push, ACK never high.
  - CLR then returns PROTO_ERR to 0.
- **Counter edge cases:**
  - CNT_WIDTH=4, 20 events with continuous reads → EVENT_CNT saturates at 15.
  - CLR coincident with a push → EVENT_CNT=1.
  - 2·FIFO_DEPTH+3 events interleaved with reads → data in order, pointer wrap correct.
- **Reset mid-handshake:** RST_N low while ACK=1 with 3 entries stored.
  - Required: ACK=0 immediately, RD_VALID=0, EVENT_CNT=0.
  - REQ still high after release → new event acknowledged after ACK_DELAY.
